// File: rtl/io_handshake_unit_if.sv
// Control-core side of the user I/O handshake: request decode inputs and
// the Moore acknowledge/data outputs returned to the core.
interface io_handshake_unit_if;
  logic        is_input;
  logic        is_output;
  logic [31:0] write_data;
  logic        confirmation;
  logic        continue_button;
  logic        waiting_user;
  logic [31:0] input_value;
  logic [31:0] display_value;

  modport master (
    output is_input,
    output is_output,
    output write_data,
    input  confirmation,
    input  continue_button,
    input  waiting_user,
    input  input_value,
    input  display_value
  );

  modport slave (
    input  is_input,
    input  is_output,
    input  write_data,
    output confirmation,
    output continue_button,
    output waiting_user,
    output input_value,
    output display_value
  );
endinterface

// File: rtl/io_handshake_unit.sv
// Debounces the confirm/continue push buttons and turns each physical press
// into exactly one acknowledge pulse for the stalled INPUT/OUTPUT/PAUSE request.
module io_handshake_unit #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SWITCH_WIDTH    = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    raw_confirm_key,
  input  logic                    raw_continue_key,
  input  logic [SWITCH_WIDTH-1:0] switches,
  io_handshake_unit_if.slave      core
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    ACK,
    WAIT_RELEASE
  } state_t;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_INPUT,
    REQ_OUTPUT,
    REQ_PAUSE
  } req_t;

  // Key index 0 is confirm, 1 is continue; internally 1 means "pressed".
  logic [1:0]       raw_pressed;
  logic [1:0]       sync_a;
  logic [1:0]       sync_b;
  logic [1:0]       sync_valid;
  logic [1:0]       level;
  logic [1:0]       seen_release;
  logic [1:0]       press_edge;
  logic [CNT_W-1:0] count [2];

  state_t      state_q;
  state_t      state_d;
  req_t        kind_q;
  req_t        kind_d;
  req_t        req_now;
  logic        capture_input;
  logic        capture_display;
  logic        serve_key;
  logic [31:0] input_value_q;
  logic [31:0] display_value_q;

  assign raw_pressed = {~raw_continue_key, ~raw_confirm_key};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_a     <= '0;
      sync_b     <= '0;
      sync_valid <= '0;
    end else begin
      sync_a     <= raw_pressed;
      sync_b     <= sync_a;
      sync_valid <= {sync_valid[0], 1'b1};
    end
  end

  // A key held through reset must be seen released once before its press
  // counts, otherwise the re-debounced level would fake a fresh press.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      level        <= '0;
      seen_release <= '0;
      press_edge   <= '0;
      count[0]     <= '0;
      count[1]     <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        press_edge[k] <= 1'b0;
        if (sync_valid[1] && !sync_b[k]) begin
          seen_release[k] <= 1'b1;
        end
        if (sync_b[k] == level[k]) begin
          count[k] <= '0;
        end else if (count[k] == CNT_LAST) begin
          count[k]      <= '0;
          level[k]      <= sync_b[k];
          press_edge[k] <= sync_b[k] & seen_release[k];
        end else begin
          count[k] <= count[k] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    req_now = REQ_NONE;
    if (core.is_input && core.is_output) begin
      req_now = REQ_PAUSE;
    end else if (core.is_input) begin
      req_now = REQ_INPUT;
    end else if (core.is_output) begin
      req_now = REQ_OUTPUT;
    end
  end

  assign serve_key = (kind_q == REQ_PAUSE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      kind_q  <= REQ_NONE;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    kind_d          = kind_q;
    capture_input   = 1'b0;
    capture_display = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_now != REQ_NONE) begin
          state_d         = WAIT_PRESS;
          kind_d          = req_now;
          capture_display = (req_now == REQ_OUTPUT);
        end
      end
      WAIT_PRESS: begin
        if (req_now != kind_q) begin
          state_d = IDLE;
        end else if (press_edge[serve_key]) begin
          state_d       = ACK;
          capture_input = (kind_q == REQ_INPUT);
        end
      end
      ACK: begin
        state_d = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (!level[serve_key]) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      input_value_q   <= '0;
      display_value_q <= '0;
    end else begin
      if (capture_input) begin
        input_value_q <= 32'(switches);
      end
      if (capture_display) begin
        display_value_q <= core.write_data;
      end
    end
  end

  assign core.confirmation    = (state_q == ACK) && (kind_q != REQ_PAUSE);
  assign core.continue_button = (state_q == ACK) && (kind_q == REQ_PAUSE);
  assign core.waiting_user    = (state_q == WAIT_PRESS);
  assign core.input_value     = input_value_q;
  assign core.display_value   = display_value_q;

endmodule

// File: tb/tb_io_handshake_unit.sv
// Directed bench for io_handshake_unit: a request/press-level model is checked
// every cycle, plus literal expectations for latency, captured data and pulse counts.
module tb_io_handshake_unit;

  localparam int DEB = 4;
  localparam int SW  = 16;

  logic          clock;
  logic          reset;
  logic          raw_confirm_key;
  logic          raw_continue_key;
  logic [SW-1:0] switches;

  io_handshake_unit_if core_if ();

  io_handshake_unit #(
    .DEBOUNCE_CYCLES(DEB),
    .SWITCH_WIDTH   (SW)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .raw_confirm_key (raw_confirm_key),
    .raw_continue_key(raw_continue_key),
    .switches        (switches),
    .core            (core_if)
  );

  int n_compared   = 0;
  int n_mismatched = 0;
  int conf_pulses  = 0;
  int cont_pulses  = 0;

  // Model: kind 0 none, 1 input, 2 output, 3 pause; key 0 confirm, 1 continue
  int          m_kind;
  bit          m_waiting;
  bit          m_ack;
  bit          m_hold;
  bit [31:0]   m_input;
  bit [31:0]   m_display;
  bit          m_level [2];
  int          m_run   [2];
  bit          m_armed [2];
  bit          m_event [2];
  bit          hist_c[$];
  bit          hist_p[$];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic apply_stimulus(input logic in_req, input logic out_req,
                                input logic conf_key, input logic cont_key);
    core_if.is_input  = in_req;
    core_if.is_output = out_req;
    raw_confirm_key   = conf_key;
    raw_continue_key  = cont_key;
  endtask

  task automatic model_clear();
    m_kind    = 0;
    m_waiting = 0;
    m_ack     = 0;
    m_hold    = 0;
    m_input   = '0;
    m_display = '0;
    for (int k = 0; k < 2; k++) begin
      m_level[k] = 0;
      m_run[k]   = 0;
      m_armed[k] = 0;
      m_event[k] = 0;
    end
    hist_c.delete();
    hist_p.delete();
  endtask

  // A press counts once the key has been stable for DEB samples taken two
  // clocks late; the request logic reacts to it on the following edge.
  initial begin
    model_clear();
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        model_clear();
      end else begin
        int req;
        int serve;
        req   = (core_if.is_input && core_if.is_output) ? 3 :
                core_if.is_input ? 1 : core_if.is_output ? 2 : 0;
        serve = (m_kind == 3) ? 1 : 0;
        if (m_hold) begin
          if (!m_level[serve]) begin
            m_hold = 0;
            m_kind = 0;
          end
        end else if (m_ack) begin
          m_ack  = 0;
          m_hold = 1;
        end else if (m_waiting) begin
          if (req != m_kind) begin
            m_waiting = 0;
            m_kind    = 0;
          end else if (m_event[serve]) begin
            m_waiting = 0;
            m_ack     = 1;
            if (m_kind == 1) m_input = {16'h0, switches};
          end
        end else if (req != 0) begin
          m_waiting = 1;
          m_kind    = req;
          if (req == 2) m_display = core_if.write_data;
        end
        hist_c.push_back(~raw_confirm_key);
        hist_p.push_back(~raw_continue_key);
        if (hist_c.size() > 3) void'(hist_c.pop_front());
        if (hist_p.size() > 3) void'(hist_p.pop_front());
        for (int k = 0; k < 2; k++) begin
          bit valid;
          bit s;
          bit was_armed;
          valid     = (k == 0) ? (hist_c.size() == 3) : (hist_p.size() == 3);
          s         = valid ? ((k == 0) ? hist_c[0] : hist_p[0]) : 1'b0;
          was_armed = m_armed[k];
          m_event[k] = 0;
          if (valid && !s) m_armed[k] = 1;
          if (s == m_level[k]) begin
            m_run[k] = 0;
          end else begin
            m_run[k]++;
            if (m_run[k] == DEB) begin
              m_run[k]   = 0;
              m_level[k] = s;
              m_event[k] = s & was_armed;
            end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (core_if.confirmation === 1'b1) conf_pulses++;
      if (core_if.continue_button === 1'b1) cont_pulses++;
      if (reset) begin
        check_output("confirmation", 32'(core_if.confirmation), 32'(m_ack && m_kind != 3));
        check_output("continue_button", 32'(core_if.continue_button), 32'(m_ack && m_kind == 3));
        check_output("waiting_user", 32'(core_if.waiting_user), 32'(m_waiting));
        check_output("input_value", core_if.input_value, m_input);
        check_output("display_value", core_if.display_value, m_display);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          base_c;
    int          base_p;
    logic        seen [1:8];

    reset              = 1'b0;
    switches           = '0;
    core_if.write_data = '0;
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1);
    tick(3);
    check_output("reset_confirmation", 32'(core_if.confirmation), 32'd0);
    check_output("reset_continue", 32'(core_if.continue_button), 32'd0);
    check_output("reset_waiting", 32'(core_if.waiting_user), 32'd0);
    check_output("reset_input_value", core_if.input_value, 32'd0);
    check_output("reset_display_value", core_if.display_value, 32'd0);
    reset = 1'b1;
    tick(10);

    $display("[TB] INPUT press latency");
    switches = 16'hA5C3;
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1);
    tick(2);
    check_output("input_waiting", 32'(core_if.waiting_user), 32'd1);
    base_c = conf_pulses;
    raw_confirm_key = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      seen[k] = core_if.confirmation;
    end
    check_output("conf_edge6", 32'(seen[6]), 32'd0);
    check_output("conf_edge7", 32'(seen[7]), 32'd1);
    check_output("conf_edge8", 32'(seen[8]), 32'd0);
    check_output("input_value_a5c3", core_if.input_value, 32'h0000A5C3);
    check_output("model_input_a5c3", m_input, 32'h0000A5C3);
    tick(4);
    check_output("input_pulse_count", 32'(conf_pulses - base_c), 32'd1);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1);
    tick(12);

    $display("[TB] OUTPUT latches write_data at request");
    core_if.write_data = 32'hDEADBEEF;
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1);
    tick(2);
    core_if.write_data = 32'h0;
    base_c = conf_pulses;
    raw_confirm_key = 1'b0;
    tick(10);
    check_output("display_deadbeef", core_if.display_value, 32'hDEADBEEF);
    check_output("model_display_deadbeef", m_display, 32'hDEADBEEF);
    check_output("output_pulse_count", 32'(conf_pulses - base_c), 32'd1);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1);
    tick(12);

    $display("[TB] PAUSE served only by continue key");
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1);
    tick(2);
    base_c = conf_pulses;
    base_p = cont_pulses;
    raw_confirm_key = 1'b0;
    tick(10);
    check_output("pause_conf_ignored", 32'(conf_pulses - base_c), 32'd0);
    check_output("pause_cont_none_yet", 32'(cont_pulses - base_p), 32'd0);
    check_output("pause_still_waiting", 32'(core_if.waiting_user), 32'd1);
    raw_confirm_key = 1'b1;
    tick(8);
    raw_continue_key = 1'b0;
    tick(10);
    check_output("pause_cont_pulse", 32'(cont_pulses - base_p), 32'd1);
    check_output("pause_conf_zero", 32'(conf_pulses - base_c), 32'd0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1);
    tick(12);

    $display("[TB] bouncing confirm key");
    switches = 16'h1234;
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1);
    tick(2);
    base_c = conf_pulses;
    repeat (3) begin
      raw_confirm_key = 1'b0;
      tick(3);
      raw_confirm_key = 1'b1;
      tick(2);
    end
    tick(6);
    check_output("bounce_no_pulse", 32'(conf_pulses - base_c), 32'd0);
    check_output("bounce_waiting", 32'(core_if.waiting_user), 32'd1);
    raw_confirm_key = 1'b0;
    tick(4);
    raw_confirm_key = 1'b1;
    tick(10);
    check_output("clean_press_pulse", 32'(conf_pulses - base_c), 32'd1);
    check_output("input_value_1234", core_if.input_value, 32'h00001234);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1);
    tick(12);

    $display("[TB] held key across two INPUT requests");
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1);
    tick(2);
    base_c = conf_pulses;
    raw_confirm_key = 1'b0;
    tick(10);
    check_output("held_first_pulse", 32'(conf_pulses - base_c), 32'd1);
    core_if.is_input = 1'b0;
    tick(2);
    core_if.is_input = 1'b1;
    tick(10);
    check_output("held_no_second", 32'(conf_pulses - base_c), 32'd1);
    check_output("held_not_waiting", 32'(core_if.waiting_user), 32'd0);
    raw_confirm_key = 1'b1;
    tick(10);
    check_output("released_waiting", 32'(core_if.waiting_user), 32'd1);
    raw_confirm_key = 1'b0;
    tick(10);
    check_output("second_pulse", 32'(conf_pulses - base_c), 32'd2);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1);
    tick(12);

    $display("[TB] request kind change while waiting");
    core_if.write_data = 32'h0BADF00D;
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1);
    tick(2);
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1);
    tick(3);
    base_c = conf_pulses;
    base_p = cont_pulses;
    raw_continue_key = 1'b0;
    tick(10);
    check_output("kind_change_display", core_if.display_value, 32'h0BADF00D);
    check_output("kind_change_no_conf", 32'(conf_pulses - base_c), 32'd0);
    check_output("kind_change_no_cont", 32'(cont_pulses - base_p), 32'd0);
    raw_confirm_key = 1'b0;
    tick(10);
    check_output("kind_change_conf", 32'(conf_pulses - base_c), 32'd1);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1);
    tick(12);

    $display("[TB] reset during WAIT_PRESS with confirm held");
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1);
    tick(2);
    raw_confirm_key = 1'b0;
    tick(2);
    reset = 1'b0;
    #1;
    check_output("midreset_confirmation", 32'(core_if.confirmation), 32'd0);
    check_output("midreset_waiting", 32'(core_if.waiting_user), 32'd0);
    check_output("midreset_input_value", core_if.input_value, 32'd0);
    check_output("midreset_display_value", core_if.display_value, 32'd0);
    tick(2);
    reset = 1'b1;
    base_c = conf_pulses;
    tick(20);
    check_output("after_reset_no_pulse", 32'(conf_pulses - base_c), 32'd0);
    check_output("after_reset_waiting", 32'(core_if.waiting_user), 32'd1);
    raw_confirm_key = 1'b1;
    tick(10);
    raw_confirm_key = 1'b0;
    tick(10);
    check_output("after_reset_repress", 32'(conf_pulses - base_c), 32'd1);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1);
    tick(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
